// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done handshake bundle for the restoring divider
//  master: drives start, dividend, divisor; observes quotient, remainder, busy, done, div_by_zero
//  slave : the divider side of the same signals
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
//  clk    : rising-edge clock
//  rst_n  : synchronous active-low reset
//  bus    : slave side of seq_restoring_divider_if
//           start/dividend/divisor in; quotient/remainder/busy/done/div_by_zero out
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seq_restoring_divider_if.slave      bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r;      // partial remainder, one bit wider so the trial subtract cannot overflow
  logic [WIDTH-1:0] q;      // dividend shifting out at the top, quotient bits shifting in at the bottom
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted_r;
  logic [WIDTH-1:0] shifted_q;
  logic [WIDTH+1:0] diff;
  logic             neg;
  logic [WIDTH:0]   next_r;
  logic [WIDTH-1:0] next_q;

  // One restoring step; the extra top bit of diff is the borrow that says "restore".
  always_comb begin
    shifted_r = {r[WIDTH-1:0], q[WIDTH-1]};
    shifted_q = q << 1;
    diff      = {1'b0, shifted_r} - {2'b00, d};
    neg       = diff[WIDTH+1];
    next_r    = neg ? shifted_r : diff[WIDTH:0];
    next_q    = {shifted_q[WIDTH-1:1], ~neg};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          r     <= next_r;
          q     <= next_q;
          count <= count + CW'(1);
          if (count == LAST_STEP) begin
            state       <= DONE;
            quotient_q  <= next_q;
            remainder_q <= next_r[WIDTH-1:0];
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept a new request identically, enabling back-to-back divisions.
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state       <= DONE;
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state  <= RUN;
              d      <= bus.divisor;
              r      <= '0;
              q      <= bus.dividend;
              count  <= '0;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called right after the accepting edge; counts cycles until done and busy cycles seen.
  task automatic wait_done(input string name, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    check({name, " done_seen"}, int'(bus.done === 1'b1), 1);
    check({name, " busy_with_done"}, int'(bus.busy === 1'b1), 0);
  endtask

  task automatic run_div(input string name, input int dvd, input int dvs,
                         input int eq, input int er, input int edz);
    int lat;
    int bc;
    int exp_lat;
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(dvd);
    bus.divisor  = WIDTH'(dvs);
    tick();
    bus.start    = 1'b0;
    // Operand changes after the accept must not matter.
    bus.dividend = ~WIDTH'(dvd);
    bus.divisor  = ~WIDTH'(dvs);
    wait_done(name, lat, bc);
    exp_lat = (edz != 0) ? 0 : WIDTH;
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy_cycles"}, bc, exp_lat);
    check({name, " quotient"}, int'(bus.quotient), eq);
    check({name, " remainder"}, int'(bus.remainder), er);
    check({name, " div_by_zero"}, int'(bus.div_by_zero), edz);
    tick();
    check({name, " done_pulse"}, int'(bus.done), 0);
    check({name, " quotient_held"}, int'(bus.quotient), eq);
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{13, 4, 3, 1, 0};
    vecs[1] = '{7, 9, 0, 7, 0};
    vecs[2] = '{15, 1, 15, 0, 0};
    vecs[3] = '{15, 15, 1, 0, 0};
    vecs[4] = '{12, 0, 15, 12, 1};
    vecs[5] = '{0, 5, 0, 0, 0};
    vecs[6] = '{1, 2, 0, 1, 0};
    vecs[7] = '{8, 3, 2, 2, 0};
    vecs[8] = '{0, 0, 15, 0, 1};
    vecs[9] = '{14, 7, 2, 0, 0};

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    check("reset quotient", int'(bus.quotient), 0);
    check("reset remainder", int'(bus.remainder), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset div_by_zero", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      run_div($sformatf("vec%0d %0d/%0d", i, vecs[i].dvd, vecs[i].dvs),
              vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Back-to-back: start held through DONE of 10/3 with new operands 9/2.
    bus.start = 1'b1; bus.dividend = 4'd10; bus.divisor = 4'd3;
    tick();
    bus.start = 1'b0;
    wait_done("b2b first", lat, bc);
    check("b2b first latency", lat, WIDTH);
    check("b2b first quotient", int'(bus.quotient), 3);
    check("b2b first remainder", int'(bus.remainder), 1);
    bus.start = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
    tick();
    bus.start = 1'b0;
    check("b2b rerun busy", int'(bus.busy), 1);
    check("b2b rerun done", int'(bus.done), 0);
    wait_done("b2b second", lat, bc);
    check("b2b second latency", lat, WIDTH);
    check("b2b second quotient", int'(bus.quotient), 4);
    check("b2b second remainder", int'(bus.remainder), 1);
    tick();

    // start while busy is ignored.
    bus.start = 1'b1; bus.dividend = 4'd10; bus.divisor = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.dividend = 4'd1; bus.divisor = 4'd1;
    tick();
    bus.start = 1'b0;
    wait_done("ignore", lat, bc);
    check("ignore latency", lat, WIDTH - 2);
    check("ignore quotient", int'(bus.quotient), 3);
    check("ignore remainder", int'(bus.remainder), 1);
    tick();

    // Reset during RUN aborts without a done pulse.
    bus.start = 1'b1; bus.dividend = 4'd10; bus.divisor = 4'd3;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.dividend = 4'd1; bus.divisor = 4'd1;
    tick();
    bus.start = 1'b0;
    check("abort busy before reset", int'(bus.busy), 1);
    rst_n = 1'b0;
    tick();
    check("abort quotient", int'(bus.quotient), 0);
    check("abort remainder", int'(bus.remainder), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort div_by_zero", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < WIDTH + 3; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1;
    end
    check("abort no done", done_seen, 0);

    // Exhaustive sweep against integer / and %.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          run_div($sformatf("ex %0d/%0d", a, b), a, b, 15, a, 1);
        else
          run_div($sformatf("ex %0d/%0d", a, b), a, b, a / b, a % b, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
